counter_updown_mod: RTL and testbench
=====================================

Name: counter_updown_mod

Overview:
Parametrised modulo up/down counter. Generalises the fixed 3-bit free-running counter with configurable width, modulus, reset value and wrap/saturate mode. Adds enable, direction control, parallel load, a terminal-count strobe and sticky overflow/underflow flags. It is used as a general event and sequence counter inside datapath and control blocks.

Parameters:
WIDTH, 3, counter width in bits (>=1)
MAX_VAL, 7, terminal value; the count sequence is 0..MAX_VAL; elaboration error if MAX_VAL > 2**WIDTH-1
RESET_VAL, 0, value loaded on reset; elaboration error if RESET_VAL > MAX_VAL
SAT_MODE, 0, 0 = wrap at boundary, 1 = saturate (hold) at boundary

Ports:
Clk  input  1  clock, all state changes on its rising edge
reset_n  input  1  synchronous active-low reset
en  input  1  count enable
up_dn  input  1  direction: 1 = increment, 0 = decrement
load  input  1  parallel load strobe
load_val  input  WIDTH  value to load
clr_flags  input  1  clears ovf and unf
count  output  WIDTH  current count (registered)
tc  output  1  terminal-count strobe (combinational from registers and inputs)
ovf  output  1  sticky: an up-count hit the MAX_VAL boundary
unf  output  1  sticky: a down-count hit the 0 boundary

Behaviour:
- Reset: reset_n and Clk are already decided as synchronous, active-low reset reset_n on clock Clk. On a rising Clk edge with reset_n=0: count=RESET_VAL, ovf=0, unf=0. Reset overrides every other input, including mid-count.
- Update priority on each rising edge: reset > load > en > hold.
- Load: when load=1, count takes load_val on the next edge. If load_val > MAX_VAL, count takes MAX_VAL (clamped). A load never sets ovf or unf, and en is ignored in that cycle.
- Count, up (en=1, up_dn=1): count+1 if count<MAX_VAL. At count==MAX_VAL, count goes to 0 (SAT_MODE=0) or holds MAX_VAL (SAT_MODE=1).
- Count, down (en=1, up_dn=0): count-1 if count>0. At count==0, count goes to MAX_VAL (SAT_MODE=0) or holds 0 (SAT_MODE=1).
- en=0 and load=0: count holds.
- Latency: one cycle. count reflects the inputs sampled on the previous rising edge.
- tc = reset_n & en & ~load & ((up_dn & count==MAX_VAL) | (~up_dn & count==0)). tc is high during the cycle whose edge performs the boundary step.
- ovf is set on an edge where tc=1 and up_dn=1. unf is set on an edge where tc=1 and up_dn=0.
- clr_flags=1 clears both flags on the next edge. If a set event and clr_flags occur on the same edge, the set wins (flag=1).
- Flags remain set while saturated and counting continues; clr_flags then re-clears and the next boundary step re-sets them.
- Arithmetic is done at WIDTH+1 bits internally. No unintended wrap at 2**WIDTH when MAX_VAL = 2**WIDTH-1.
- Direction may change on any cycle; there is no extra latency.
- Bounds: count never exceeds MAX_VAL in any mode.

Decomposition:
- Package counter_pkg holds:
  - mode constants CNT_WRAP=0 and CNT_SAT=1
  - a function next_count(cur, up, max, sat) returning the next value and a boundary bit.
- No sub-module. The block is a single always block for count, one for the flags, and a continuous assign for tc.

Test Plan:
- Defaults, reset_n low 5 cycles, then en=1, up_dn=1 -> count 0,1,..,7,0,1. tc high only while count=7. ovf=1 from the edge leaving 7.
- WIDTH=4, MAX_VAL=9, down-count from reset 0 -> count 9,8,..,0,9. unf=1 after the first step. tc high at every count=0 with en=1.
- SAT_MODE=1, WIDTH=3, MAX_VAL=5, count up 8 cycles -> count 1..5 then holds 5. ovf=1. Then up_dn=0 -> 4,3.
- load=1, load_val=6 with MAX_VAL=5 -> count=5. Simultaneous load=1, load_val=2, en=1 -> count=2, tc=0, no flag change.
- ovf=1, then clr_flags=1 on the same edge as a new wrap -> ovf stays 1. Next cycle clr_flags=1 with no event -> ovf=0.
- Reset mid-count: count=4, reset_n=0 for one edge -> count=RESET_VAL (run with RESET_VAL=3 -> 3), flags 0. Counting resumes from 3 on the following edge.

Source files
------------

// File: rtl/counter_updown_mod_pkg.sv
// Shared definitions for the modulo up/down counter: mode constants and the
// single-step next-value helper used by the counter datapath.
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Widest counter the helper supports. Arithmetic is carried out one bit
  // wider so that MAX_VAL = 2**WIDTH-1 never wraps silently.
  localparam int CNT_MAXW = 32;

  // Boundary flag sits above the value so the value occupies the LSBs and a
  // plain size cast of the whole result yields the next count.
  typedef struct packed {
    logic                boundary;
    logic [CNT_MAXW:0]   value;
  } next_count_t;

  function automatic next_count_t next_count(
    input logic [CNT_MAXW:0] cur,
    input logic              up,
    input logic [CNT_MAXW:0] max,
    input logic              sat
  );
    next_count_t res;
    res.boundary = 1'b0;
    res.value    = cur;
    if (up) begin
      if (cur == max) begin
        res.boundary = 1'b1;
        res.value    = sat ? max : '0;
      end else begin
        res.value = cur + {{CNT_MAXW{1'b0}}, 1'b1};
      end
    end else begin
      if (cur == '0) begin
        res.boundary = 1'b1;
        res.value    = sat ? '0 : max;
      end else begin
        res.value = cur - {{CNT_MAXW{1'b0}}, 1'b1};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/counter_updown_mod.sv
// Parametrised modulo up/down counter with parallel load, terminal-count
// strobe and sticky overflow/underflow flags. Wrap or saturate at the ends.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int MAX_VAL   = 7,
  parameter int RESET_VAL = 0,
  parameter int SAT_MODE  = CNT_WRAP
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RESET_VAL);
  localparam logic             SAT_EN  = (SAT_MODE != CNT_WRAP);

  // Reject configurations whose count range cannot be represented.
  if (WIDTH < 1 || WIDTH > CNT_MAXW) begin : g_bad_width
    $error("counter_updown_mod: WIDTH must be in 1..%0d", CNT_MAXW);
  end
  if (MAX_VAL < 0 || 64'(MAX_VAL) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_max
    $error("counter_updown_mod: MAX_VAL does not fit in WIDTH bits");
  end
  if (RESET_VAL < 0 || RESET_VAL > MAX_VAL) begin : g_bad_reset
    $error("counter_updown_mod: RESET_VAL must be in 0..MAX_VAL");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;
  logic [WIDTH-1:0] w_stepVal;
  logic [WIDTH-1:0] w_loadVal;

  assign w_stepVal = WIDTH'(next_count((CNT_MAXW+1)'({1'b0, r_count}), up_dn,
                                       (CNT_MAXW+1)'(MAX_VAL), SAT_EN));

  assign w_loadVal = ({1'b0, load_val} > MAX_EXT) ? MAX_W : load_val;

  assign tc = reset_n & en & ~load &
              ((up_dn & (r_count == MAX_W)) | (~up_dn & (r_count == '0)));

  assign count = r_count;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

  // Count register: reset beats load, load beats counting, otherwise hold.
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_count <= RST_W;
    end else if (load) begin
      r_count <= w_loadVal;
    end else if (en) begin
      r_count <= w_stepVal;
    end
  end

  // Sticky boundary flags: a boundary step sets, clr_flags clears, set wins.
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (tc & up_dn)  | (r_ovf & ~clr_flags);
      r_unf <= (tc & ~up_dn) | (r_unf & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench for counter_updown_mod: five configurations share one
// stimulus stream; a behavioural model predicts tc and the post-edge state.
module tb_counter_updown_mod;

  localparam int NDUT = 5;
  localparam int P_W[NDUT]   = '{3, 4, 3, 3, 4};
  localparam int P_MAX[NDUT] = '{7, 9, 5, 5, 15};
  localparam int P_RST[NDUT] = '{0, 0, 0, 3, 0};
  localparam int P_SAT[NDUT] = '{0, 0, 1, 0, 0};

  typedef struct packed {
    logic [NDUT-1:0]      tc;
    logic [NDUT-1:0][3:0] cnt;
    logic [NDUT-1:0]      ovf;
    logic [NDUT-1:0]      unf;
  } exp_t;

  logic Clk;
  logic resetN;
  logic en;
  logic upDn;
  logic load;
  logic [3:0] loadVal;
  logic clrFlags;

  logic [2:0] cnt0, cnt2, cnt3;
  logic [3:0] cnt1, cnt4;
  logic [NDUT-1:0] dutTc, dutOvf, dutUnf;
  logic [NDUT-1:0][3:0] dutCnt;

  exp_t expQ[$];
  int   mCnt[NDUT];
  bit   mOvf[NDUT];
  bit   mUnf[NDUT];
  int   nChecks = 0;
  int   nFail   = 0;
  bit   driveDone   = 0;
  bit   monitorDone = 0;

  assign dutCnt[0] = {1'b0, cnt0};
  assign dutCnt[1] = cnt1;
  assign dutCnt[2] = {1'b0, cnt2};
  assign dutCnt[3] = {1'b0, cnt3};
  assign dutCnt[4] = cnt4;

  counter_updown_mod #(.WIDTH(3), .MAX_VAL(7), .RESET_VAL(0), .SAT_MODE(0)) u_dut0 (
    .Clk(Clk), .reset_n(resetN), .en(en), .up_dn(upDn), .load(load),
    .load_val(loadVal[2:0]), .clr_flags(clrFlags), .count(cnt0),
    .tc(dutTc[0]), .ovf(dutOvf[0]), .unf(dutUnf[0]));

  counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(0), .SAT_MODE(0)) u_dut1 (
    .Clk(Clk), .reset_n(resetN), .en(en), .up_dn(upDn), .load(load),
    .load_val(loadVal), .clr_flags(clrFlags), .count(cnt1),
    .tc(dutTc[1]), .ovf(dutOvf[1]), .unf(dutUnf[1]));

  counter_updown_mod #(.WIDTH(3), .MAX_VAL(5), .RESET_VAL(0), .SAT_MODE(1)) u_dut2 (
    .Clk(Clk), .reset_n(resetN), .en(en), .up_dn(upDn), .load(load),
    .load_val(loadVal[2:0]), .clr_flags(clrFlags), .count(cnt2),
    .tc(dutTc[2]), .ovf(dutOvf[2]), .unf(dutUnf[2]));

  counter_updown_mod #(.WIDTH(3), .MAX_VAL(5), .RESET_VAL(3), .SAT_MODE(0)) u_dut3 (
    .Clk(Clk), .reset_n(resetN), .en(en), .up_dn(upDn), .load(load),
    .load_val(loadVal[2:0]), .clr_flags(clrFlags), .count(cnt3),
    .tc(dutTc[3]), .ovf(dutOvf[3]), .unf(dutUnf[3]));

  counter_updown_mod #(.WIDTH(4), .MAX_VAL(15), .RESET_VAL(0), .SAT_MODE(0)) u_dut4 (
    .Clk(Clk), .reset_n(resetN), .en(en), .up_dn(upDn), .load(load),
    .load_val(loadVal), .clr_flags(clrFlags), .count(cnt4),
    .tc(dutTc[4]), .ovf(dutOvf[4]), .unf(dutUnf[4]));

  // Free-running clock, period 10.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Compare one observed value with its prediction and tally the result.
  task automatic checkOutput(input string name, input int idx, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s dut%0d at %0t: got %0d, expected %0d", name, idx, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, predict this cycle's tc and the state after
  // the coming edge for every configuration, and queue the prediction.
  task automatic applyStimulus(input bit rst, input bit e, input bit u,
                               input bit l, input int lv, input bit clr);
    exp_t ex;
    @(posedge Clk);
    #2;
    resetN   = rst;
    en       = e;
    upDn     = u;
    load     = l;
    loadVal  = 4'(lv);
    clrFlags = clr;
    for (int i = 0; i < NDUT; i++) begin
      int  lvI;
      int  mx;
      bit  atEnd;
      bit  tcE;
      mx    = P_MAX[i];
      lvI   = lv & ((1 << P_W[i]) - 1);
      atEnd = u ? (mCnt[i] == mx) : (mCnt[i] == 0);
      tcE   = rst && e && !l && atEnd;
      if (!rst) begin
        mCnt[i] = P_RST[i];
        mOvf[i] = 0;
        mUnf[i] = 0;
      end else begin
        if (l) begin
          mCnt[i] = (lvI > mx) ? mx : lvI;
        end else if (e) begin
          if (u) mCnt[i] = atEnd ? (P_SAT[i] != 0 ? mx : 0) : mCnt[i] + 1;
          else   mCnt[i] = atEnd ? (P_SAT[i] != 0 ? 0 : mx) : mCnt[i] - 1;
        end
        mOvf[i] = (tcE && u)  ? 1'b1 : (clr ? 1'b0 : mOvf[i]);
        mUnf[i] = (tcE && !u) ? 1'b1 : (clr ? 1'b0 : mUnf[i]);
      end
      ex.tc[i]  = tcE;
      ex.cnt[i] = 4'(mCnt[i]);
      ex.ovf[i] = mOvf[i];
      ex.unf[i] = mUnf[i];
    end
    expQ.push_back(ex);
  endtask

  // Monitor: tc is checked mid-cycle, registered state just after the edge.
  initial begin
    exp_t ex;
    forever begin
      @(negedge Clk);
      if (expQ.size() > 0) begin
        ex = expQ.pop_front();
        for (int i = 0; i < NDUT; i++) checkOutput("tc", i, int'(dutTc[i]), int'(ex.tc[i]));
        @(posedge Clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
          checkOutput("count", i, int'(dutCnt[i]), int'(ex.cnt[i]));
          checkOutput("ovf",   i, int'(dutOvf[i]), int'(ex.ovf[i]));
          checkOutput("unf",   i, int'(dutUnf[i]), int'(ex.unf[i]));
        end
      end else if (driveDone) begin
        break;
      end
    end
    monitorDone = 1;
  end

  // Hard stop if the run never completes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no end, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic, then the summary.
  initial begin
    resetN   = 1'b0;
    en       = 1'b0;
    upDn     = 1'b1;
    load     = 1'b0;
    loadVal  = 4'd0;
    clrFlags = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      mCnt[i] = 0;
      mOvf[i] = 0;
      mUnf[i] = 0;
    end

    repeat (5)  applyStimulus(0, 0, 1, 0, 0, 0);
    repeat (10) applyStimulus(1, 1, 1, 0, 0, 0);

    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (12) applyStimulus(1, 1, 0, 0, 0, 0);

    applyStimulus(0, 0, 1, 0, 0, 0);
    repeat (8) applyStimulus(1, 1, 1, 0, 0, 0);
    repeat (2) applyStimulus(1, 1, 0, 0, 0, 0);

    applyStimulus(1, 0, 1, 1, 6, 0);
    applyStimulus(1, 1, 1, 1, 2, 0);
    applyStimulus(1, 0, 1, 1, 15, 0);
    applyStimulus(1, 1, 1, 1, 9, 0);

    applyStimulus(0, 0, 1, 0, 0, 0);
    repeat (15) applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 1);
    applyStimulus(1, 0, 1, 0, 0, 1);

    applyStimulus(0, 0, 1, 0, 0, 0);
    repeat (4) applyStimulus(1, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    repeat (3) applyStimulus(1, 1, 1, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                    int'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
    end

    driveDone = 1;
    for (int w = 0; w < 20 && !monitorDone; w++) @(posedge Clk);
    if (!monitorDone) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
